w5300_bus_arbiter: RTL and testbench

// - Shares the single W5300 parallel-interface access port among NUM_REQ requesters.

---
 rtl/w5300_bus_arbiter_pkg.sv | 46 ++++
 rtl/w5300_bus_arbiter_rr_pick.sv | 29 ++
 rtl/w5300_bus_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_w5300_bus_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/w5300_bus_arbiter_pkg.sv
// Shared constants, W5300 register map and FSM state type for the W5300 bus arbiter.
// caddr is {invalid, read, address[9:0]}; the helper builds an active access word.
package w5300_bus_arbiter_pkg;

  localparam int CADDR_INVALID_BIT = 11;
  localparam int CADDR_RD_BIT      = 10;

  localparam logic [11:0] CADDR_IDLE = 12'h800;

  // W5300 register addresses (10-bit word-aligned offsets)
  localparam logic [9:0] W5300_MR     = 10'h000;
  localparam logic [9:0] W5300_IR     = 10'h002;
  localparam logic [9:0] W5300_IMR    = 10'h004;
  localparam logic [9:0] W5300_IDR    = 10'h0FE;
  localparam logic [9:0] W5300_S0_MR  = 10'h200;
  localparam logic [9:0] W5300_S0_CR  = 10'h202;
  localparam logic [9:0] W5300_S0_IR  = 10'h206;
  localparam logic [9:0] W5300_S0_SSR = 10'h208;

  localparam logic [15:0] W5300_IR_S0_MASK = 16'h0001;
  localparam logic [15:0] W5300_SN_IR_RECV = 16'h0004;

  localparam logic [7:0] SN_CR_OPEN    = 8'h01;
  localparam logic [7:0] SN_CR_LISTEN  = 8'h02;
  localparam logic [7:0] SN_CR_CONNECT = 8'h04;
  localparam logic [7:0] SN_CR_DISCON  = 8'h08;
  localparam logic [7:0] SN_CR_CLOSE   = 8'h10;
  localparam logic [7:0] SN_CR_SEND    = 8'h20;
  localparam logic [7:0] SN_CR_RECV    = 8'h40;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } arb_state_t;

  function automatic logic [11:0] make_caddr(input logic rd, input logic [9:0] addr);
    logic [11:0] c;
    c                    = '0;
    c[CADDR_INVALID_BIT] = 1'b0;
    c[CADDR_RD_BIT]      = rd;
    c[9:0]               = addr;
    return c;
  endfunction

endpackage

// File: rtl/w5300_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request scanning upward from last+1
// with wrap, so the previous winner has the lowest priority.
module w5300_bus_arbiter_rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         last,
  output logic [2:0]         winner,
  output logic               any
);

  logic [7:0] req_ext;
  logic [2:0] idx;

  always_comb begin
    req_ext = 8'(req);
    winner  = last;
    any     = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = 3'((int'(last) + k) % NUM_REQ);
      if (!any && req_ext[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/w5300_bus_arbiter.sv
// Round-robin arbiter sharing the W5300 parallel-interface port among NUM_REQ requesters,
// with optional lock for atomic sequences and a per-access timeout.
module w5300_bus_arbiter
  import w5300_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_rd,
  input  logic [NUM_REQ-1:0]    req_lock,
  input  logic [NUM_REQ*10-1:0] req_addr,
  input  logic [NUM_REQ*16-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    ack,
  output logic [15:0]           ack_rdata,
  output logic                  ack_err,
  output logic [2:0]            gnt_id,
  output logic                  busy,
  output logic                  bus_err,
  output logic [11:0]           caddr,
  output logic [15:0]           wr_data,
  input  logic [15:0]           rd_data,
  input  logic                  op_status
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  arb_state_t state_q, state_d;
  logic [2:0]         gnt_q, gnt_d;
  logic               lock_q, lock_d;
  logic               rd_q, rd_d;
  logic [9:0]         addr_q, addr_d;
  logic [15:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [11:0]        caddr_q, caddr_d;
  logic [15:0]        wr_data_q, wr_data_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [15:0]        ack_rdata_q, ack_rdata_d;
  logic               ack_err_q, ack_err_d;
  logic               busy_q, busy_d;
  logic               bus_err_q, bus_err_d;

  logic [7:0]  valid_ext, rd_ext, lock_ext;
  logic [9:0]  addr_arr  [8];
  logic [15:0] wdata_arr [8];
  logic [2:0]  rr_winner, sel;
  logic        rr_any, lock_hold, do_grant;

  // Widen per-requester fields to 8 entries so a 3-bit index always selects exactly.
  always_comb begin
    valid_ext = 8'(req_valid);
    rd_ext    = 8'(req_rd);
    lock_ext  = 8'(req_lock);
    for (int i = 0; i < 8; i++) begin
      addr_arr[i]  = '0;
      wdata_arr[i] = '0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[10*i +: 10];
      wdata_arr[i] = req_wdata[16*i +: 16];
    end
  end

  w5300_bus_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req    (req_valid),
    .last   (gnt_q),
    .winner (rr_winner),
    .any    (rr_any)
  );

  // A held lock overrides round-robin only while its owner keeps requesting.
  always_comb begin
    lock_hold = lock_q && valid_ext[gnt_q];
    sel       = lock_hold ? gnt_q : rr_winner;
    do_grant  = lock_hold || rr_any;
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    lock_d      = lock_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    caddr_d     = caddr_q;
    wr_data_d   = wr_data_q;
    ack_d       = '0;
    ack_rdata_d = ack_rdata_q;
    ack_err_d   = ack_err_q;
    busy_d      = busy_q;
    bus_err_d   = bus_err_q;

    unique case (state_q)
      S_IDLE: begin
        caddr_d = CADDR_IDLE;
        if (!lock_hold) lock_d = 1'b0;
        if (do_grant) begin
          gnt_d     = sel;
          rd_d      = rd_ext[sel];
          addr_d    = addr_arr[sel];
          wdata_d   = wdata_arr[sel];
          lock_d    = lock_ext[sel];
          caddr_d   = make_caddr(rd_ext[sel], addr_arr[sel]);
          wr_data_d = wdata_arr[sel];
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_ISSUE;
        end
      end

      // op_status is checked before the timeout so a completion in the last cycle is not an error.
      S_ISSUE: begin
        caddr_d   = make_caddr(rd_q, addr_q);
        wr_data_d = wdata_q;
        cnt_d     = cnt_q + CNT_W'(1);
        if (op_status) begin
          ack_rdata_d = rd_data;
          ack_err_d   = 1'b0;
          ack_d       = NUM_REQ'(1) << gnt_q;
          caddr_d     = CADDR_IDLE;
          state_d     = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          ack_rdata_d = 16'h0000;
          ack_err_d   = 1'b1;
          bus_err_d   = 1'b1;
          ack_d       = NUM_REQ'(1) << gnt_q;
          caddr_d     = CADDR_IDLE;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        caddr_d = CADDR_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        caddr_d = CADDR_IDLE;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= 3'(NUM_REQ - 1);
      lock_q      <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      caddr_q     <= CADDR_IDLE;
      wr_data_q   <= '0;
      ack_q       <= '0;
      ack_rdata_q <= '0;
      ack_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      lock_q      <= lock_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      caddr_q     <= caddr_d;
      wr_data_q   <= wr_data_d;
      ack_q       <= ack_d;
      ack_rdata_q <= ack_rdata_d;
      ack_err_q   <= ack_err_d;
      busy_q      <= busy_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign ack       = ack_q;
  assign ack_rdata = ack_rdata_q;
  assign ack_err   = ack_err_q;
  assign gnt_id    = gnt_q;
  assign busy      = busy_q;
  assign bus_err   = bus_err_q;
  assign caddr     = caddr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_w5300_bus_arbiter.sv
// Self-checking bench for w5300_bus_arbiter: per-requester access queues, a parallel_if
// model with per-access latency, and a round-robin/lock reference model at the queue level.
module tb_w5300_bus_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int TIMEOUT_CYC = 200;

  logic                  clk, rst_n;
  logic [NUM_REQ-1:0]    req_valid, req_rd, req_lock, ack;
  logic [NUM_REQ*10-1:0] req_addr;
  logic [NUM_REQ*16-1:0] req_wdata;
  logic [15:0]           ack_rdata, wr_data, rd_data;
  logic                  ack_err, busy, bus_err, op_status;
  logic [2:0]            gnt_id;
  logic [11:0]           caddr;

  w5300_bus_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .ack_rdata (ack_rdata),
    .ack_err   (ack_err),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .bus_err   (bus_err),
    .caddr     (caddr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .op_status (op_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          lock;
    logic [9:0]  addr;
    logic [15:0] wdata;
    int          delay;
    logic [15:0] rdata;
  } access_t;

  access_t pend [NUM_REQ][$];
  access_t cur;
  int      cur_req, issue_cnt;
  bit      in_flight, prev_ack;
  int      m_last;
  bit      m_lock, m_bus_err;
  int      grant_log [$];
  int      total_checks, bad_checks;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < NUM_REQ; i++) if (pend[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Reference arbitration: locked owner keeps the bus while it has work, else next pending after last.
  function automatic int model_pick();
    if (m_lock && pend[m_last].size() > 0) return m_last;
    m_lock = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++)
      if (pend[(m_last + k) % NUM_REQ].size() > 0) return (m_last + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic push_access(input int r, input bit rd, input bit lock, input logic [9:0] addr,
                             input logic [15:0] wdata, input int delay, input logic [15:0] rdata);
    access_t a;
    a.rd = rd; a.lock = lock; a.addr = addr; a.wdata = wdata; a.delay = delay; a.rdata = rdata;
    pend[r].push_back(a);
  endtask

  task automatic apply_stimulus();
    for (int i = 0; i < NUM_REQ; i++) begin
      if ((in_flight && i == cur_req) || pend[i].size() == 0) begin
        req_valid[i]          = (in_flight && i == cur_req) ? 1'($urandom_range(0, 1)) : 1'b0;
        req_rd[i]             = 1'($urandom_range(0, 1));
        req_lock[i]           = 1'($urandom_range(0, 1));
        req_addr[10*i +: 10]  = 10'($urandom);
        req_wdata[16*i +: 16] = 16'($urandom);
      end else begin
        req_valid[i]          = 1'b1;
        req_rd[i]             = pend[i][0].rd;
        req_lock[i]           = pend[i][0].lock;
        req_addr[10*i +: 10]  = pend[i][0].addr;
        req_wdata[16*i +: 16] = pend[i][0].wdata;
      end
    end
    if (in_flight && issue_cnt == cur.delay) begin
      op_status = 1'b1;
      rd_data   = cur.rdata;
    end else begin
      op_status = !in_flight && ($urandom_range(0, 5) == 0);
      rd_data   = 16'($urandom);
    end
  endtask

  task automatic monitor_cycle();
    bit ack_now, grant_seen, exp_grant, exp_err;
    int exp_len, w;
    ack_now = 1'b0;
    if (in_flight) begin
      if (ack != '0) begin
        ack_now = 1'b1;
        exp_err = (cur.delay > TIMEOUT_CYC);
        exp_len = exp_err ? TIMEOUT_CYC : cur.delay;
        if (exp_err) m_bus_err = 1'b1;
        check_output("ack_onehot", 32'(ack), 32'(1) << cur_req);
        check_output("issue_len", issue_cnt, exp_len);
        check_output("ack_err", 32'(ack_err), 32'(exp_err));
        check_output("ack_rdata", 32'(ack_rdata), exp_err ? 32'h0 : 32'(cur.rdata));
        check_output("bus_err", 32'(bus_err), 32'(m_bus_err));
        check_output("done_caddr_inv", 32'(caddr[11]), 32'h1);
        void'(pend[cur_req].pop_front());
        in_flight = 1'b0;
      end else begin
        issue_cnt++;
        check_output("issue_caddr", 32'(caddr), {21'h0, cur.rd, cur.addr});
        if (issue_cnt > TIMEOUT_CYC + 2) begin
          check_output("ack_watchdog", 32'h0, 32'h1);
          void'(pend[cur_req].pop_front());
          in_flight = 1'b0;
        end
      end
    end else begin
      grant_seen = ~caddr[11];
      exp_grant  = !prev_ack && (req_valid != '0);
      check_output("grant_present", 32'(grant_seen), 32'(exp_grant));
      if (grant_seen && exp_grant) begin
        w = model_pick();
        check_output("gnt_id", 32'(gnt_id), w);
        check_output("grant_caddr", 32'(caddr), {21'h0, pend[w][0].rd, pend[w][0].addr});
        check_output("grant_wr_data", 32'(wr_data), 32'(pend[w][0].wdata));
        check_output("busy_issue", 32'(busy), 32'h1);
        cur       = pend[w][0];
        cur_req   = w;
        m_last    = w;
        m_lock    = cur.lock;
        in_flight = 1'b1;
        issue_cnt = 1;
        grant_log.push_back(w);
      end else if (!grant_seen) begin
        check_output("busy_idle", 32'(busy), 32'h0);
        if (!prev_ack) m_lock = 1'b0;
      end
    end
    prev_ack = ack_now;
  endtask

  task automatic step_cycle();
    @(negedge clk);
    monitor_cycle();
    apply_stimulus();
  endtask

  task automatic run_until_drained(input int max_cycles);
    int n;
    n = 0;
    while ((any_pending() || in_flight) && n < max_cycles) begin
      step_cycle();
      n++;
    end
    if (n >= max_cycles) check_output("drain_budget", 32'h0, 32'h1);
    repeat (2) step_cycle();
  endtask

  task automatic reset_bench_state();
    for (int i = 0; i < NUM_REQ; i++) pend[i].delete();
    in_flight = 1'b0; prev_ack = 1'b0; issue_cnt = 0;
    m_last = NUM_REQ - 1; m_lock = 1'b0; m_bus_err = 1'b0;
    req_valid = '0; req_rd = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    op_status = 1'b0; rd_data = '0;
    grant_log.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_caddr"}, 32'(caddr), 32'h800);
    check_output({tag, "_ack"}, 32'(ack), 32'h0);
    check_output({tag, "_busy"}, 32'(busy), 32'h0);
    check_output({tag, "_gnt_id"}, 32'(gnt_id), NUM_REQ - 1);
    check_output({tag, "_bus_err"}, 32'(bus_err), 32'h0);
    check_output({tag, "_ack_err"}, 32'(ack_err), 32'h0);
    check_output({tag, "_ack_rdata"}, 32'(ack_rdata), 32'h0);
    check_output({tag, "_wr_data"}, 32'(wr_data), 32'h0);
  endtask

  initial begin
    int fair_exp [8];
    int lock_exp [5];
    int n;
    fair_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
    lock_exp = '{2, 2, 2, 3, 0};
    total_checks = 0; bad_checks = 0; cur_req = 0;
    rst_n = 1'b0;
    reset_bench_state();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // Fairness: all requesters keep two accesses queued.
    for (int r = 0; r < NUM_REQ; r++)
      for (int k = 0; k < 2; k++)
        push_access(r, 1'b0, 1'b0, 10'($urandom), 16'($urandom), $urandom_range(1, 4), 16'($urandom));
    apply_stimulus();
    run_until_drained(200);
    for (int i = 0; i < 8; i++)
      check_output("fair_order", (i < grant_log.size()) ? grant_log[i] : -1, fair_exp[i]);

    push_access(0, 1'b0, 1'b0, 10'h202, 16'h0100, 5, 16'($urandom));
    run_until_drained(50);
    push_access(1, 1'b1, 1'b0, 10'h0FE, 16'($urandom), 3, 16'h5300);
    run_until_drained(50);

    // Lock: requester 2 owns the bus for three accesses while 0 and 3 wait.
    grant_log.delete();
    push_access(2, 1'b0, 1'b1, 10'h202, 16'h0001, 4, 16'($urandom));
    push_access(2, 1'b1, 1'b1, 10'h208, 16'h0000, 3, 16'h0017);
    push_access(2, 1'b0, 1'b0, 10'h206, 16'h00FF, 2, 16'($urandom));
    n = 0;
    while (!in_flight && n < 10) begin step_cycle(); n++; end
    push_access(0, 1'b1, 1'b0, 10'h002, 16'h0, 2, 16'h0001);
    push_access(3, 1'b0, 1'b0, 10'h000, 16'h8000, 3, 16'($urandom));
    apply_stimulus();
    run_until_drained(100);
    for (int i = 0; i < 5; i++)
      check_output("lock_order", (i < grant_log.size()) ? grant_log[i] : -1, lock_exp[i]);

    // Timeout, then completion exactly in the final allowed cycle.
    push_access(1, 1'b0, 1'b0, 10'h204, 16'h1234, 1000, 16'hDEAD);
    run_until_drained(TIMEOUT_CYC + 20);
    push_access(0, 1'b1, 1'b0, 10'h0FE, 16'h0, TIMEOUT_CYC, 16'h5300);
    run_until_drained(TIMEOUT_CYC + 20);
    check_output("bus_err_sticky", 32'(bus_err), 32'h1);

    for (int round = 0; round < 6; round++) begin
      for (int k = 0; k < 6; k++)
        push_access($urandom_range(0, NUM_REQ - 1), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                    10'($urandom), 16'($urandom), $urandom_range(1, 10), 16'($urandom));
      apply_stimulus();
      run_until_drained(400);
    end

    // Asynchronous reset in the middle of an access.
    push_access(3, 1'b0, 1'b0, 10'h200, 16'h4242, 60, 16'($urandom));
    apply_stimulus();
    n = 0;
    while (!(in_flight && issue_cnt >= 3) && n < 20) begin step_cycle(); n++; end
    check_output("mid_issue_reached", 32'(in_flight), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("mid_reset");
    reset_bench_state();
    repeat (2) @(negedge clk);
    check_output("reset_no_ack", 32'(ack), 32'h0);
    rst_n = 1'b1;
    push_access(2, 1'b0, 1'b0, 10'h202, 16'h0010, 2, 16'($urandom));
    push_access(0, 1'b1, 1'b0, 10'h000, 16'h0, 2, 16'h3800);
    apply_stimulus();
    run_until_drained(50);
    check_output("post_reset_first", (grant_log.size() > 0) ? grant_log[0] : -1, 32'h0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
